// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-word constants and hatch FSM state type
package cpu_pkg;
  localparam int INSTR_W = 48;
  localparam int BYTES_PER_INSTR = 6;
  localparam logic [INSTR_W-1:0] NOP_WORD = 48'h0;
  typedef enum logic {RUN, LOAD} hatch_state_t;
endpackage

// File: rtl/cpu_hatch_ram.sv
// cpu_hatch_ram: single-write/single-read synchronous RAM with old-data read-during-write
module cpu_hatch_ram #(
  parameter int ADDR_W = 10,
  parameter int W = 48
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/cpu_hatch.sv
// cpu_hatch: instruction store serving CPU fetches and assembling host byte loads
module cpu_hatch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter logic [47:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       hatch_address,
  output logic [47:0]       hatch_instruction,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              load_done,
  output logic              cpu_rst_b,
  output logic [ADDR_W:0]   load_count,
  output logic              load_overflow
);
  hatch_state_t state, next_state;
  logic [2:0] byte_cnt;
  logic [INSTR_W-1:0] asm_word, ram_q;
  logic in_range_q, take, full, last, we;
  always_comb begin
    next_state = load_start ? LOAD : (state == LOAD && load_done) ? RUN : state;
    load_ready = state == LOAD && !load_done;
    take = load_valid && load_ready && !load_start;
    // count never exceeds 2^ADDR_W, so the top bit alone marks the store full
    full = load_count[ADDR_W];
    last = byte_cnt == 3'(BYTES_PER_INSTR - 1);
    we = take && !full && last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cpu_rst_b <= 1'b0;
      byte_cnt <= '0;
      load_count <= '0;
      load_overflow <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      state <= next_state;
      cpu_rst_b <= next_state == RUN;
      in_range_q <= hatch_address[31:ADDR_W] == '0;
      if (load_start) begin
        byte_cnt <= '0;
        load_count <= '0;
        load_overflow <= 1'b0;
      end else if (take && full) begin
        load_overflow <= 1'b1;
      end else if (take) begin
        byte_cnt <= last ? 3'd0 : byte_cnt + 3'd1;
        if (last) load_count <= load_count + (ADDR_W+1)'(1);
      end
    end
  end
  always_ff @(posedge clk)
    if (take && !full) asm_word[{byte_cnt, 3'b000} +: 8] <= load_data;
  cpu_hatch_ram #(.ADDR_W(ADDR_W), .W(INSTR_W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(load_count[ADDR_W-1:0]),
    .wdata({load_data, asm_word[39:0]}),
    .raddr(hatch_address[ADDR_W-1:0]),
    .rdata(ram_q)
  );
  assign hatch_instruction = in_range_q ? ram_q : NOP_WORD;
endmodule

// File: tb/tb_cpu_hatch.sv
// tb_cpu_hatch: scoreboard bench driving a 1024-word and a 4-word store with one load stream
module tb_cpu_hatch;
  logic clk = 0, rst = 1;
  logic [31:0] a_addr = 0, b_addr = 0;
  logic load_start = 0, load_valid = 0, load_done = 0;
  logic [7:0] load_data = 0;
  logic [47:0] a_instr, b_instr;
  logic a_ready, b_ready, a_crb, b_crb, a_ovf, b_ovf;
  logic [10:0] a_cnt;
  logic [2:0] b_cnt;
  logic req = 0, pend = 0;
  logic [47:0] qa[$], qb[$];
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  cpu_hatch #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .hatch_address(a_addr), .hatch_instruction(a_instr),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(a_ready), .load_done(load_done), .cpu_rst_b(a_crb),
    .load_count(a_cnt), .load_overflow(a_ovf)
  );
  cpu_hatch #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .hatch_address(b_addr), .hatch_instruction(b_instr),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(b_ready), .load_done(load_done), .cpu_rst_b(b_crb),
    .load_count(b_cnt), .load_overflow(b_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) pend <= req;

  always @(negedge clk)
    if (pend) begin
      if (qa.size() == 0 || qb.size() == 0) chk("fetch_queue_empty", 64'(qa.size() + qb.size()), 64'd2);
      else begin
        chk("fetch_a", 64'(a_instr), 64'(qa.pop_front()));
        chk("fetch_b", 64'(b_instr), 64'(qb.pop_front()));
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    load_valid = 1;
    load_data = b;
    step();
    load_valid = 0;
  endtask

  task automatic pulse_start();
    load_start = 1;
    step();
    load_start = 0;
  endtask

  task automatic pulse_done();
    load_done = 1;
    step();
    load_done = 0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [47:0] ea, input logic [31:0] b, input logic [47:0] eb);
    a_addr = a;
    b_addr = b;
    qa.push_back(ea);
    qb.push_back(eb);
    req = 1;
    step();
    req = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_instr", 64'(a_instr), 64'h0);
    chk("rst_crb", 64'({a_crb, b_crb}), 64'h0);
    chk("rst_ready", 64'({a_ready, b_ready}), 64'h0);
    chk("rst_cnt_ovf", 64'({a_cnt, a_ovf, b_cnt, b_ovf}), 64'h0);
    rst = 0;
    step();
    @(negedge clk);
    chk("crb_after_rst", 64'({a_crb, b_crb}), 64'h3);
    // two full words
    pulse_start();
    @(negedge clk);
    chk("load_entry", 64'({a_crb, a_ready, b_crb, b_ready}), 64'b0101);
    for (int i = 1; i <= 6; i++) send(8'(i));
    for (int i = 1; i <= 6; i++) send(8'(8'h10 + i));
    pulse_done();
    @(negedge clk);
    chk("cnt2", 64'({a_cnt, b_cnt}), {50'h0, 11'd2, 3'd2});
    chk("exit_crb", 64'({a_crb, a_ready}), 64'b10);
    fetch(0, 48'h060504030201, 0, 48'h060504030201);
    fetch(1, 48'h161514131211, 1, 48'h161514131211);
    fetch(32'h400, 48'h0, 4, 48'h0);
    // one word plus a discarded partial
    pulse_start();
    for (int i = 1; i <= 8; i++) send(8'(8'h20 + i));
    @(negedge clk);
    chk("crb_low_loading", 64'(a_crb), 64'h0);
    pulse_done();
    @(negedge clk);
    chk("cnt_partial", 64'({a_cnt, b_cnt}), {50'h0, 11'd1, 3'd1});
    chk("crb_rise", 64'({a_crb, b_crb}), 64'h3);
    fetch(0, 48'h262524232221, 0, 48'h262524232221);
    fetch(1, 48'h161514131211, 1, 48'h161514131211);
    // restart mid word 1
    pulse_start();
    for (int i = 1; i <= 6; i++) send(8'(8'h30 + i));
    for (int i = 1; i <= 3; i++) send(8'(8'h40 + i));
    pulse_start();
    @(negedge clk);
    chk("restart_cnt", 64'({a_cnt, b_cnt}), 64'h0);
    for (int i = 1; i <= 6; i++) send(8'(8'h50 + i));
    pulse_done();
    @(negedge clk);
    chk("restart_cnt1", 64'({a_cnt, b_cnt}), {50'h0, 11'd1, 3'd1});
    fetch(0, 48'h565554535251, 0, 48'h565554535251);
    fetch(1, 48'h161514131211, 1, 48'h161514131211);
    // five words: the 4-word store overflows without wrapping
    pulse_start();
    for (int i = 0; i < 30; i++) send(8'(8'h60 + i));
    @(negedge clk);
    chk("ovf_ready_held", 64'(b_ready), 64'h1);
    pulse_done();
    @(negedge clk);
    chk("ovf_a", 64'({a_cnt, a_ovf}), {52'h0, 11'd5, 1'b0});
    chk("ovf_b", 64'({b_cnt, b_ovf}), {60'h0, 3'd4, 1'b1});
    fetch(0, 48'h656463626160, 0, 48'h656463626160);
    fetch(4, 48'h7d7c7b7a7978, 3, 48'h777675747372);
    // reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 9; i++) send(8'(8'h90 + i));
    #1 rst = 1;
    #1;
    chk("midrst_outs", 64'({a_crb, a_ready, b_crb, b_ready}), 64'h0);
    @(negedge clk);
    rst = 0;
    load_valid = 1;
    step();
    @(negedge clk);
    chk("after_midrst", 64'({a_crb, a_ready, a_cnt}), {51'h0, 2'b10, 11'd0});
    load_valid = 0;
    fetch(0, 48'h959493929190, 0, 48'h959493929190);
    fetch(1, 48'h6b6a69686766, 1, 48'h6b6a69686766);
    step();
    step();
    chk("queue_drained", 64'(qa.size() + qb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_hatch.md
# cpu_hatch

Instruction store that answers the fetch stage's hatch requests: it returns the 48-bit instruction word for each `hatch_address` one cycle later. It also accepts a byte-wide program-load stream from the host side and assembles six bytes into each 48-bit word. While a load is in progress it holds the CPU in reset. It sits beside `cpu` at board top level, between the host loader and the fetch port.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; store depth = 2^ADDR_W words.
- `NOP_WORD`, default 48'h0: word returned for out-of-range fetch addresses.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous, active-high.
- `hatch_address`  in  32  fetch word address, from CPU.
- `hatch_instruction`  out  48  instruction for the previous cycle's `hatch_address`.
- `load_start`  in  1  one-cycle pulse: begin a program load.
- `load_valid`  in  1  `load_data` is valid.
- `load_data`  in  8  program byte, least-significant byte of each word first.
- `load_ready`  out  1  the block accepts the byte this cycle.
- `load_done`  in  1  one-cycle pulse: end the program load.
- `cpu_rst_b`  out  1  active-low reset to CPU; low while loading.
- `load_count`  out  ADDR_W+1  number of words committed by the current/last load.
- `load_overflow`  out  1  sticky flag: bytes arrived after the store was full.

## Operation
- FSM states: RUN, LOAD.
  - Reset state is RUN.
  - RUN → LOAD on `load_start`. Entering LOAD clears the write pointer, byte counter, `load_count` and `load_overflow`.
  - LOAD → RUN on `load_done`. `load_done` has priority over a same-cycle byte; that byte is not accepted.
  - `load_start` while in LOAD restarts the load: pointer and counters are cleared and the state stays LOAD.
- Byte assembly:
  - A byte is accepted when `load_valid && load_ready`.
  - `load_ready` = 1 in LOAD, except in the `load_done` cycle.
  - Accepted bytes shift into a 48-bit assembly register at byte lane `byte_cnt` (0..5).
  - On the 6th byte, the full word (that byte included) is written to `mem[wptr]` in the same cycle. Then `wptr++`, `load_count++`, and `byte_cnt` returns to 0.
  - A partial word (1–5 bytes) pending at `load_done` is discarded; `load_count` is unchanged.
- Full condition: when `load_count == 2^ADDR_W`, further accepted bytes are dropped (no write, no wrap) and `load_overflow` is set. `load_ready` stays 1 so the host never stalls.
- Fetch path:
  - Synchronous read: `hatch_instruction <= in_range ? mem[hatch_address[ADDR_W-1:0]] : NOP_WORD`.
  - `in_range` = `hatch_address[31:ADDR_W] == 0`.
  - Reads continue in both states.
  - Read-during-write to the same word returns the old data.
- `cpu_rst_b` = 0 in LOAD or during `rst`, and 1 in RUN. It is registered (glitch-free).
- Memory contents are not cleared by `rst`.

## Timing
- Reset values: `hatch_instruction` = `NOP_WORD`, `cpu_rst_b` = 0, `load_ready` = 0, `load_count` = 0, `load_overflow` = 0, state = RUN.
- First cycle after reset deassertion: `cpu_rst_b` goes to 1 on the next clock edge.
- Fetch latency: exactly 1 cycle, with a new address accepted every cycle.
- LOAD entry: `cpu_rst_b` falls and `load_ready` rises in the cycle after the `load_start` edge.
- LOAD exit: `cpu_rst_b` rises in the cycle after the `load_done` edge. The CPU therefore restarts at PC 0 with the last committed word visible.
- Write commit: the word written on edge N is readable by a fetch presented at edge N+1, with data appearing at N+2.
- Asserting `rst` mid-load returns the block to RUN. Words already committed stay in memory; the partial word is lost.

## Structure
- Shared package `cpu_pkg`: `INSTR_W` = 48, `BYTES_PER_INSTR` = 6, FSM state enum `hatch_state_t`. `NOP_WORD` is also defined there so the decode stage and this block agree.
- One sub-module, `cpu_hatch_ram`: a single-port-write / single-port-read synchronous RAM, 48 × 2^ADDR_W, with old-data read-during-write, written so it infers block RAM.
- The FSM, assembler and fetch mux live in `cpu_hatch`.

## Test plan
- Load 2 words as bytes 01..06, 11..16 → `load_count` = 2; fetch addr 0 → 48'h060504030201; fetch addr 1 → 48'h161514131211, each 1 cycle later.
- `load_done` after 8 bytes → `load_count` = 1; `mem[1]` unchanged; `cpu_rst_b` rises the next cycle.
- Fetch `hatch_address` = 32'h0000_0400 (ADDR_W = 10) → `hatch_instruction` = `NOP_WORD`.
- ADDR_W = 2: stream 5 words (30 bytes) → `load_count` = 4, `load_overflow` = 1, `mem[0]` keeps word 0 (no wrap).
- `load_start` at byte 3 of word 1 → `load_count` = 0, the next 6 bytes write `mem[0]`.
- Assert `rst` mid-load → `cpu_rst_b` = 0, `load_ready` = 0 immediately; after release, state = RUN and committed words are still readable.
